ysyx_22040127_mdu_div_ctrl: RTL and testbench

Requester-side controller for the 64-bit multi-cycle divider `ysyx_22040127_div`. It sits in the EXU between the decoded M-extension division ops (DIV/DIVU/REM/REMU and their W forms) and the divider. It formats operands, launches the divider with a one-cycle start pulse, and holds operands stable until the divider's `ready`. It also short-circuits the RISC-V divide-by-zero and signed-overflow cases, selects and sign-extends the result, and handles pipeline flush.

---
 rtl/ysyx_22040127_mdu_pkg.sv | 25 ++
 rtl/ysyx_22040127_div_special.sv | 47 ++++
 rtl/ysyx_22040127_mdu_div_ctrl.sv | 135 +++++++++++++
 tb/tb_ysyx_22040127_mdu_div_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040127_mdu_pkg.sv
// Shared constants and types for the M-extension divide path:
// op encodings, controller state encoding and the W-op sign-extension helper.
package ysyx_22040127_mdu_pkg;

    localparam int unsigned XLEN         = 64;
    localparam logic [63:0] INT64_MIN    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] INT32_MIN_SX = 64'hFFFF_FFFF_8000_0000;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } div_state_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22040127_div_special.sv
// Combinational operand formatting plus RISC-V divide-by-zero / signed-overflow
// detection; supplies the short-circuit result so the divider is never started.
module ysyx_22040127_div_special
    import ysyx_22040127_mdu_pkg::*;
(
    input  logic [1:0]      i_op,
    input  logic            i_w,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    output logic [XLEN-1:0] o_x,
    output logic [XLEN-1:0] o_y,
    output logic            o_signed,
    output logic            o_special,
    output logic [XLEN-1:0] o_result
);

    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_min;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_sel;

    always_comb begin
        o_signed = ~i_op[0];
        if (i_w) begin
            o_x   = o_signed ? sext32(i_src1[31:0]) : {32'd0, i_src1[31:0]};
            o_y   = o_signed ? sext32(i_src2[31:0]) : {32'd0, i_src2[31:0]};
            w_min = INT32_MIN_SX;
        end else begin
            o_x   = i_src1;
            o_y   = i_src2;
            w_min = INT64_MIN;
        end

        w_div0    = (o_y == '0);
        w_ovf     = o_signed & (o_x == w_min) & (o_y == '1);
        o_special = w_div0 | w_ovf;

        // Overflow yields quotient = dividend, remainder = 0
        w_quo    = w_div0 ? '1  : o_x;
        w_rem    = w_div0 ? o_x : '0;
        w_sel    = i_op[1] ? w_rem : w_quo;
        o_result = i_w ? sext32(w_sel[31:0]) : w_sel;
    end

endmodule

// File: rtl/ysyx_22040127_mdu_div_ctrl.sv
// Requester-side controller for the multi-cycle divider: accepts one op at a time,
// launches the divider, holds operands until ready, and handles flush/drain.
module ysyx_22040127_mdu_div_ctrl #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic            req_w,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    output logic            req_ready,
    input  logic            flush,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic [XLEN-1:0] div_x,
    output logic [XLEN-1:0] div_y,
    output logic            div_s,
    output logic            div_is_div,
    input  logic            div_ready,
    input  logic [XLEN-1:0] div_quo,
    input  logic [XLEN-1:0] div_rem
);

    import ysyx_22040127_mdu_pkg::div_state_e;
    import ysyx_22040127_mdu_pkg::ST_IDLE;
    import ysyx_22040127_mdu_pkg::ST_BUSY;
    import ysyx_22040127_mdu_pkg::ST_DRAIN;
    import ysyx_22040127_mdu_pkg::ST_RESP;
    import ysyx_22040127_mdu_pkg::sext32;

    div_state_e      r_state;
    logic            r_rem_sel;
    logic            r_w;
    logic            r_start;
    logic            r_resp;
    logic            r_s;
    logic [XLEN-1:0] r_x;
    logic [XLEN-1:0] r_y;
    logic [XLEN-1:0] r_result;

    logic [XLEN-1:0] w_x;
    logic [XLEN-1:0] w_y;
    logic            w_s;
    logic            w_special;
    logic [XLEN-1:0] w_special_result;
    logic [XLEN-1:0] w_div_sel;
    logic            w_accept;

    ysyx_22040127_div_special u_special (
        .i_op      (req_op),
        .i_w       (req_w),
        .i_src1    (req_src1),
        .i_src2    (req_src2),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_signed  (w_s),
        .o_special (w_special),
        .o_result  (w_special_result)
    );

    assign req_ready  = (r_state == ST_IDLE) & ~flush & ~rst;
    assign w_accept   = req_valid & req_ready;
    assign busy       = (r_state == ST_BUSY) | (r_state == ST_DRAIN) |
                        ((r_state == ST_IDLE) & req_valid);
    assign w_div_sel  = r_rem_sel ? div_rem : div_quo;

    // A flush arriving in the response cycle must still kill the registered pulse
    assign resp_valid = r_resp & ~flush;
    assign resp_data  = r_result;
    assign div_x      = r_x;
    assign div_y      = r_y;
    assign div_s      = r_s;
    assign div_is_div = r_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rem_sel <= 1'b0;
            r_w       <= 1'b0;
            r_start   <= 1'b0;
            r_resp    <= 1'b0;
            r_s       <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_result  <= '0;
        end else begin
            r_start <= 1'b0;
            r_resp  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rem_sel <= req_op[1];
                        r_w       <= req_w;
                        if (w_special) begin
                            r_result <= w_special_result;
                            r_resp   <= 1'b1;
                            r_state  <= ST_RESP;
                        end else begin
                            r_x     <= w_x;
                            r_y     <= w_y;
                            r_s     <= w_s;
                            r_start <= 1'b1;
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    // Flush coinciding with ready has nothing left to drain
                    if (flush) begin
                        r_state <= div_ready ? ST_IDLE : ST_DRAIN;
                    end else if (div_ready) begin
                        r_result <= r_w ? sext32(w_div_sel[31:0]) : w_div_sel;
                        r_resp   <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_DRAIN: begin
                    if (div_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040127_mdu_div_ctrl.sv
// Bench for the divide controller: behavioural divider beside the DUT, a RISC-V
// reference model for results, and one per-cycle monitor checking the outputs.
module tb_ysyx_22040127_mdu_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic        req_w;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        busy;
    logic [63:0] div_x;
    logic [63:0] div_y;
    logic        div_s;
    logic        div_is_div;
    logic        div_ready;
    logic [63:0] div_quo;
    logic [63:0] div_rem;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    logic        mon_en = 1'b0;

    typedef struct {
        logic [63:0] data;
        logic        special;
        int unsigned acc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Last accepted op, as the reference model sees it
    logic        acc_live = 1'b0;
    logic        acc_special = 1'b0;
    int unsigned acc_cyc = 0;
    logic [63:0] acc_x, acc_y;
    logic        acc_s;

    // Divider model state
    int unsigned div_lat = 67;
    logic        dm_active = 1'b0;
    int unsigned dm_cnt = 0;
    logic [63:0] dm_x = '0, dm_y = '0;
    logic        dm_s = 1'b0;
    logic        rst_s;
    int unsigned rdy_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_22040127_mdu_div_ctrl #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_w      (req_w),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy),
        .div_x      (div_x),
        .div_y      (div_y),
        .div_s      (div_s),
        .div_is_div (div_is_div),
        .div_ready  (div_ready),
        .div_quo    (div_quo),
        .div_rem    (div_rem)
    );

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V M-extension result, computed directly on 32- or 64-bit integers
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, q, r;
        int              ta, tb;
        logic [63:0]     res;
        if (w) begin
            if (!op[0]) begin
                ta = a[31:0]; tb = b[31:0];
                sa = ta;      sb = tb;
                if (sb == 0) begin q = '1; r = sa; end
                else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin q = sa; r = 0; end
                else begin q = sa / sb; r = sa % sb; end
            end else begin
                ua = {32'd0, a[31:0]}; ub = {32'd0, b[31:0]};
                if (ub == 0) begin q = '1; r = ua; end
                else begin q = ua / ub; r = ua % ub; end
            end
            res = op[1] ? r : q;
            return {{32{res[31]}}, res[31:0]};
        end
        if (!op[0]) begin
            sa = a; sb = b;
            if (sb == 0) begin q = '1; r = sa; end
            else if (a == 64'h8000_0000_0000_0000 && b == '1) begin q = sa; r = 0; end
            else begin q = sa / sb; r = sa % sb; end
        end else begin
            ua = a; ub = b;
            if (ub == 0) begin q = '1; r = ua; end
            else begin q = ua / ub; r = ua % ub; end
        end
        return op[1] ? r : q;
    endfunction

    function automatic logic [63:0] fmt(input logic [1:0] op, input logic w, input logic [63:0] v);
        if (!w) return v;
        if (op[0]) return {32'd0, v[31:0]};
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic is_special(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
        logic [63:0] fx, fy, mn;
        fx = fmt(op, w, a);
        fy = fmt(op, w, b);
        mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        return (fy == 0) || (!op[0] && fx == mn && fy == '1);
    endfunction

    // Behavioural divider: ready exactly div_lat cycles after the start pulse
    initial begin
        div_ready = 1'b0;
        div_quo   = '0;
        div_rem   = '0;
        forever begin
            @(posedge clk);
            rst_s = rst;
            #1;
            div_ready = 1'b0;
            if (rst_s) begin
                dm_active = 1'b0;
            end else if (div_is_div) begin
                dm_active = 1'b1;
                dm_cnt    = div_lat;
                dm_x      = div_x;
                dm_y      = div_y;
                dm_s      = div_s;
            end else if (dm_active) begin
                dm_cnt--;
                if (dm_cnt == 0) begin
                    dm_active = 1'b0;
                    div_ready = 1'b1;
                    rdy_cyc   = cyc;
                    if (dm_y == 0) begin
                        div_quo = '1; div_rem = dm_x;
                    end else if (dm_s && dm_x == 64'h8000_0000_0000_0000 && dm_y == '1) begin
                        div_quo = dm_x; div_rem = '0;
                    end else if (dm_s) begin
                        div_quo = $signed(dm_x) / $signed(dm_y);
                        div_rem = $signed(dm_x) % $signed(dm_y);
                    end else begin
                        div_quo = dm_x / dm_y;
                        div_rem = dm_x % dm_y;
                    end
                end
            end
        end
    end

    // Per-cycle monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (dm_active || div_ready) chk1("busy_during_div", busy, 1'b1);
            else if (!req_valid)        chk1("busy_idle", busy, 1'b0);

            if (acc_live && cyc == acc_cyc + 1) begin
                chk1("div_is_div", div_is_div, !acc_special);
                if (!acc_special) begin
                    chk64("div_x_fmt", div_x, acc_x);
                    chk64("div_y_fmt", div_y, acc_y);
                    chk1("div_s_fmt", div_s, acc_s);
                end
            end else if (div_is_div) begin
                chk1("div_is_div_unexpected", div_is_div, 1'b0);
            end

            if ((dm_active || div_ready) && !div_is_div) begin
                chk64("div_x_hold", div_x, dm_x);
                chk64("div_y_hold", div_y, dm_y);
                chk1("div_s_hold", div_s, dm_s);
            end

            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk1("resp_valid_unexpected", resp_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk64("resp_data", resp_data, mon_e.data);
                    chkn("resp_latency", cyc, mon_e.special ? mon_e.acc + 1 : rdy_cyc + 1);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic present(input logic [1:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b);
        req_valid = 1'b1; req_op = op; req_w = w; req_src1 = a; req_src2 = b;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc_cyc     = cyc;
                acc_special = is_special(op, w, a, b);
                acc_x       = fmt(op, w, a);
                acc_y       = fmt(op, w, b);
                acc_s       = ~op[0];
                acc_live    = 1'b1;
                exp_q.push_back('{data: ref_result(op, w, a, b), special: acc_special, acc: cyc});
                @(posedge clk); #1;
                req_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk1("accept_timeout", 1'b0, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chkn("resp_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_lit(input string name, input logic [1:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] lit);
        chk64({name, "_model"}, ref_result(op, w, a, b), lit);
        present(op, w, a, b);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b;
        int unsigned mode;

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_w = 1'b0;
        req_src1 = '0; req_src2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk64("rst_resp_data", resp_data, '0);
        chk1("rst_div_is_div", div_is_div, 1'b0);
        chk64("rst_div_x", div_x, '0);
        chk64("rst_div_y", div_y, '0);
        chk1("rst_div_s", div_s, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk1("req_ready_after_rst", req_ready, 1'b1);
        @(posedge clk); #1;

        div_lat = 67;
        run_lit("div_m7_2",   2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_lit("rem_m7_2",   2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run_lit("divu_5_0",   2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_lit("remu_5_0",   2'b11, 1'b0, 64'd5, 64'd0, 64'd5);
        run_lit("div_ovf",    2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
        run_lit("rem_ovf",    2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0);
        run_lit("divw_ovf",   2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                64'hFFFF_FFFF_8000_0000);
        run_lit("divw_m16_3", 2'b00, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        run_lit("divuw",      2'b01, 1'b1, 64'h1_8000_0000, 64'd2, 64'h0000_0000_4000_0000);

        // Flush ten cycles into BUSY, then a new op waits for the drain
        present(2'b00, 1'b0, 64'd1000, 64'd3);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        chk64("div_100_7_model", ref_result(2'b00, 1'b0, 64'd100, 64'd7), 64'd14);
        present(2'b00, 1'b0, 64'd100, 64'd7);
        chkn("accept_after_drain", acc_cyc, rdy_cyc + 1);
        wait_done();

        // Flush in IDLE blocks the same-cycle request
        flush = 1'b1; req_valid = 1'b1; req_op = 2'b01; req_w = 1'b0;
        req_src1 = 64'd9; req_src2 = 64'd0;
        @(negedge clk);
        chk1("req_ready_flush", req_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        present(2'b01, 1'b0, 64'd9, 64'd0);
        wait_done();

        // Flush in the response cycle suppresses resp_valid
        present(2'b00, 1'b0, 64'd9, 64'd0);
        flush = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;

        // Reset while BUSY, then a fresh op
        present(2'b00, 1'b0, 64'd77, 64'd5);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        exp_q.delete();
        acc_live = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("midrst_resp_valid", resp_valid, 1'b0);
        chk64("midrst_resp_data", resp_data, '0);
        chk1("midrst_div_is_div", div_is_div, 1'b0);
        chk64("midrst_div_x", div_x, '0);
        chk64("midrst_div_y", div_y, '0);
        chk1("midrst_div_s", div_s, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        run_lit("div_77_5", 2'b00, 1'b0, 64'd77, 64'd5, 64'd15);

        // Randomised ops with varying divider latency
        for (int n = 0; n < 60; n++) begin
            div_lat = $urandom_range(1, 8);
            op   = 2'($urandom_range(0, 3));
            w    = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 5);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (mode)
                1: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
                2: b = w ? {b[63:32], 32'd0} : 64'd0;
                3: begin
                    a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
                end
                4: begin a = -64'($urandom_range(1, 1000)); b = 64'($urandom_range(1, 30)); end
                default: ;
            endcase
            present(op, w, a, b);
            wait_done();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
